block_dispatcher: RTL and testbench
===================================

Name: block_dispatcher

Overview:
Multi-core block dispatcher for the GPU top level. It accepts a kernel launch through a valid/ready handshake and splits the thread count into fixed-size blocks. Blocks are handed to NUM_CORES compute cores with round-robin fairness, and each block's completion is tracked. The block adds several things a fixed 2-core/8-bit dispatcher does not have: parametrised widths, multi-retire per cycle, an abort path, zero-thread launches, and busy/progress status.

Parameters:
NUM_CORES, 4, number of compute cores driven (>=1)
THREADS_PER_BLOCK, 4, threads per block; power of two >=1
COUNT_WIDTH, 16, width of launch thread count
BLOCK_ID_WIDTH, 16, width of block index and block counters; must satisfy 2^BLOCK_ID_WIDTH > ceil((2^COUNT_WIDTH-1)/THREADS_PER_BLOCK)
TC_WIDTH is a localparam equal to $clog2(THREADS_PER_BLOCK)+1.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
launch_valid  in  1  launch request
launch_ready  out  1  high only in IDLE
launch_thread_count  in  COUNT_WIDTH  total threads, sampled on handshake
abort  in  1  cancel current kernel (honoured in RUN only)
core_done  in  NUM_CORES  per-core completion, level
core_start  out  NUM_CORES  per-core run enable
core_reset  out  NUM_CORES  per-core reset pulse
core_block_id  out  NUM_CORES x BLOCK_ID_WIDTH  block index per core
core_thread_count  out  NUM_CORES x TC_WIDTH  active threads in that block
busy  out  1  kernel in flight (state != IDLE)
done  out  1  one-cycle pulse on normal completion
aborted  out  1  one-cycle pulse on abort completion
blocks_retired  out  BLOCK_ID_WIDTH  blocks completed in current kernel

Behaviour:
- Reset values: state=IDLE, every slot FREE, core_start=0, core_reset=all 1s, core_block_id=0, core_thread_count=THREADS_PER_BLOCK, done=0, aborted=0, blocks_retired=0, rr pointer=0. On the first cycle after reset, core_reset goes to 0.
- Reset mid-kernel behaves identically; no completion pulse is produced.
- total_blocks = ceil(count/THREADS_PER_BLOCK), computed once at handshake and registered.
- Last block thread count = count - (total_blocks-1)*THREADS_PER_BLOCK (range 1..THREADS_PER_BLOCK). All other blocks get THREADS_PER_BLOCK.
- Top FSM, IDLE: launch_ready=1. On launch_valid&&launch_ready, latch count and clear counters.
  - If count==0: go to FINISH.
  - Otherwise go to RUN.
- Top FSM, RUN:
  - Dispatch at most one block per cycle while next_block < total_blocks.
  - Retire any number of blocks per cycle.
  - When blocks_retired + retirements_this_cycle == total_blocks, go to FINISH.
- Top FSM, FINISH: done=1 for exactly one cycle, then IDLE. A new launch is accepted only once back in IDLE.
- Top FSM, ABORT: lasts one cycle. aborted=1, core_reset=all 1s, core_start=0, all slots FREE. Then IDLE.
  - abort has priority over dispatch and retire in the same cycle.
  - abort outside RUN is ignored.
- Per-core slot FSM, FREE->LOAD: on dispatch grant, load core_block_id=next_block and core_thread_count, assert core_reset=1 for one cycle, next_block++.
- Per-core slot FSM, LOAD->RUNNING: next cycle, core_reset=0 and core_start=1. core_start stays high while RUNNING.
- Per-core slot FSM, RUNNING->FREE: when core_done=1 (sampled only in RUNNING), core_start=0 next cycle and blocks_retired increments by the popcount of retiring slots.
  - core_done in FREE or LOAD is ignored.
- Round-robin grant: search FREE slots starting at the rr pointer, wrapping at NUM_CORES. After a grant to slot k, rr=(k+1) mod NUM_CORES.
- A slot freed in cycle t is eligible for grant at t+1 at the earliest. A given core therefore has ≥1 idle cycle between blocks.
- core_block_id and core_thread_count hold their values after retirement until the next grant.

Test Plan:
- Launch count=16, TPB=4, NUM_CORES=4, cores done 5 cycles after start -> block ids 0,1,2,3 granted to cores 0..3 on consecutive cycles; each core_reset pulse is 1 cycle; done pulses once; blocks_retired=4; busy falls with done.
- Launch count=10, TPB=4, NUM_CORES=2 -> 3 blocks; thread counts 4,4,2; block 2 goes to the first core that frees.
- All 4 cores assert core_done in the same cycle -> blocks_retired +4 in one cycle; next grants resume round-robin from the pointer.
- Launch count=0 -> launch_ready drops, done pulses 2 cycles after the handshake, no core_start ever asserted.
- Abort while 3 blocks are running -> next cycle aborted=1, core_reset=all 1s, core_start=0; done never pulses; a new launch is accepted the following cycle.
- Assert reset mid-kernel, and separately assert core_done on a FREE slot -> reset restores all reset values with no done/aborted pulse; the spurious core_done leaves blocks_retired unchanged.

Source files
------------

// File: rtl/block_dispatcher_if.sv
// Launch handshake, per-core control and status bundle for the block dispatcher.
// Pure wiring; no storage or latency of its own.
// The launch uses a valid/ready handshake. Core signals are level enables and pulses, with no backpressure.
interface block_dispatcher_if #(
    parameter int NUM_CORES      = 4,
    parameter int COUNT_WIDTH    = 16,
    parameter int BLOCK_ID_WIDTH = 16,
    parameter int TC_WIDTH       = 3
);
    logic                                      launch_valid;
    logic                                      launch_ready;
    logic [COUNT_WIDTH-1:0]                    launch_thread_count;
    logic                                      abort;
    logic [NUM_CORES-1:0]                      core_done;
    logic [NUM_CORES-1:0]                      core_start;
    logic [NUM_CORES-1:0]                      core_reset;
    logic [NUM_CORES-1:0][BLOCK_ID_WIDTH-1:0]  core_block_id;
    logic [NUM_CORES-1:0][TC_WIDTH-1:0]        core_thread_count;
    logic                                      busy;
    logic                                      done;
    logic                                      aborted;
    logic [BLOCK_ID_WIDTH-1:0]                 blocks_retired;

    // Host / core side: drives launches, abort and core completions.
    modport master (
        output launch_valid, launch_thread_count, abort, core_done,
        input  launch_ready, core_start, core_reset, core_block_id,
               core_thread_count, busy, done, aborted, blocks_retired
    );

    // Dispatcher side.
    modport slave (
        input  launch_valid, launch_thread_count, abort, core_done,
        output launch_ready, core_start, core_reset, core_block_id,
               core_thread_count, busy, done, aborted, blocks_retired
    );
endinterface

// File: rtl/block_dispatcher.sv
// Splits a kernel launch into fixed-size thread blocks and hands them round-robin to NUM_CORES cores.
// A granted core sees core_reset the cycle after the grant and core_start the cycle after that; done follows one cycle after FINISH.
// A launch is accepted only in IDLE (launch_ready). Any number of blocks retire per cycle, at most one dispatch per cycle.
module block_dispatcher #(
    parameter int NUM_CORES         = 4,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int COUNT_WIDTH       = 16,
    parameter int BLOCK_ID_WIDTH    = 16
) (
    input  logic              clk,
    input  logic              reset,
    block_dispatcher_if.slave bus
);
    localparam int TPB_LOG2 = $clog2(THREADS_PER_BLOCK);
    localparam int TC_WIDTH = TPB_LOG2 + 1;
    localparam int RR_WIDTH = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [TC_WIDTH-1:0]    TPB_TC   = TC_WIDTH'(THREADS_PER_BLOCK);
    localparam logic [COUNT_WIDTH-1:0] TPB_MASK = COUNT_WIDTH'(THREADS_PER_BLOCK - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FINISH, ST_ABORT} state_t;
    typedef enum logic [1:0] {SLOT_FREE, SLOT_LOAD, SLOT_RUNNING} slot_t;

    state_t                                   state_q, state_d;
    slot_t                                    slot_q [NUM_CORES];
    slot_t                                    slot_d [NUM_CORES];
    logic [BLOCK_ID_WIDTH-1:0]                total_blocks_q, total_blocks_d;
    logic [TC_WIDTH-1:0]                      last_tc_q, last_tc_d;
    logic [BLOCK_ID_WIDTH-1:0]                next_block_q, next_block_d;
    logic [BLOCK_ID_WIDTH-1:0]                blocks_retired_q, blocks_retired_d;
    logic [RR_WIDTH-1:0]                      rr_q, rr_d;
    logic [NUM_CORES-1:0]                     core_start_q, core_start_d;
    logic [NUM_CORES-1:0]                     core_reset_q, core_reset_d;
    logic [NUM_CORES-1:0][BLOCK_ID_WIDTH-1:0] core_block_id_q, core_block_id_d;
    logic [NUM_CORES-1:0][TC_WIDTH-1:0]       core_thread_count_q, core_thread_count_d;
    logic                                     done_q, done_d;
    logic                                     aborted_q, aborted_d;

    // Launch decode: block count rounds up; a partial last block carries the remainder.
    logic [BLOCK_ID_WIDTH-1:0] launch_blocks;
    logic [COUNT_WIDTH-1:0]    launch_rem;
    logic [TC_WIDTH-1:0]       launch_last_tc;
    assign launch_blocks  = BLOCK_ID_WIDTH'(({1'b0, bus.launch_thread_count}
                            + (COUNT_WIDTH+1)'(THREADS_PER_BLOCK - 1)) >> TPB_LOG2);
    assign launch_rem     = bus.launch_thread_count & TPB_MASK;
    assign launch_last_tc = (launch_rem == '0) ? TPB_TC : TC_WIDTH'(launch_rem);

    // Round-robin search for the first FREE slot at or after the rr pointer.
    logic                grant_vld;
    logic [RR_WIDTH-1:0] grant_idx;
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            if (!grant_vld && slot_q[idx] == SLOT_FREE) begin
                grant_vld = 1'b1;
                grant_idx = RR_WIDTH'(idx);
            end
        end
    end

    // Slots finishing this cycle; core_done only counts for RUNNING slots.
    logic [NUM_CORES-1:0]      retire_mask;
    logic [BLOCK_ID_WIDTH-1:0] retire_cnt;
    always_comb begin
        retire_cnt = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            retire_mask[k] = (state_q == ST_RUN) && (slot_q[k] == SLOT_RUNNING) && bus.core_done[k];
            retire_cnt     = retire_cnt + BLOCK_ID_WIDTH'(retire_mask[k]);
        end
    end

    // Next-state logic for the top FSM, the slot FSMs and all registered outputs.
    always_comb begin
        logic abort_take;
        state_d             = state_q;
        slot_d              = slot_q;
        total_blocks_d      = total_blocks_q;
        last_tc_d           = last_tc_q;
        next_block_d        = next_block_q;
        blocks_retired_d    = blocks_retired_q;
        rr_d                = rr_q;
        core_block_id_d     = core_block_id_q;
        core_thread_count_d = core_thread_count_q;
        done_d              = (state_q == ST_FINISH);
        aborted_d           = 1'b0;
        abort_take          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.launch_valid) begin
                    total_blocks_d   = launch_blocks;
                    last_tc_d        = launch_last_tc;
                    next_block_d     = '0;
                    blocks_retired_d = '0;
                    state_d          = (bus.launch_thread_count == '0) ? ST_FINISH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    // Abort wins over any dispatch or retirement this cycle.
                    abort_take = 1'b1;
                    aborted_d  = 1'b1;
                    state_d    = ST_ABORT;
                    for (int k = 0; k < NUM_CORES; k++) slot_d[k] = SLOT_FREE;
                end else begin
                    for (int k = 0; k < NUM_CORES; k++) begin
                        if (slot_q[k] == SLOT_LOAD) slot_d[k] = SLOT_RUNNING;
                        if (retire_mask[k])         slot_d[k] = SLOT_FREE;
                    end
                    blocks_retired_d = blocks_retired_q + retire_cnt;
                    if (blocks_retired_d == total_blocks_q) state_d = ST_FINISH;
                    if (grant_vld && (next_block_q < total_blocks_q)) begin
                        slot_d[grant_idx]              = SLOT_LOAD;
                        core_block_id_d[grant_idx]     = next_block_q;
                        core_thread_count_d[grant_idx] =
                            (next_block_q == total_blocks_q - 1'b1) ? last_tc_q : TPB_TC;
                        next_block_d = next_block_q + 1'b1;
                        rr_d = (int'(grant_idx) == NUM_CORES - 1) ? '0 : grant_idx + 1'b1;
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            ST_ABORT:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        for (int k = 0; k < NUM_CORES; k++) begin
            core_start_d[k] = (slot_d[k] == SLOT_RUNNING);
            core_reset_d[k] = (slot_d[k] == SLOT_LOAD) || abort_take;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q             <= ST_IDLE;
            for (int k = 0; k < NUM_CORES; k++) slot_q[k] <= SLOT_FREE;
            total_blocks_q      <= '0;
            last_tc_q           <= TPB_TC;
            next_block_q        <= '0;
            blocks_retired_q    <= '0;
            rr_q                <= '0;
            core_start_q        <= '0;
            core_reset_q        <= '1;
            core_block_id_q     <= '0;
            core_thread_count_q <= {NUM_CORES{TPB_TC}};
            done_q              <= 1'b0;
            aborted_q           <= 1'b0;
        end else begin
            state_q             <= state_d;
            slot_q              <= slot_d;
            total_blocks_q      <= total_blocks_d;
            last_tc_q           <= last_tc_d;
            next_block_q        <= next_block_d;
            blocks_retired_q    <= blocks_retired_d;
            rr_q                <= rr_d;
            core_start_q        <= core_start_d;
            core_reset_q        <= core_reset_d;
            core_block_id_q     <= core_block_id_d;
            core_thread_count_q <= core_thread_count_d;
            done_q              <= done_d;
            aborted_q           <= aborted_d;
        end
    end

    assign bus.launch_ready      = (state_q == ST_IDLE);
    assign bus.busy              = (state_q != ST_IDLE);
    assign bus.core_start        = core_start_q;
    assign bus.core_reset        = core_reset_q;
    assign bus.core_block_id     = core_block_id_q;
    assign bus.core_thread_count = core_thread_count_q;
    assign bus.done              = done_q;
    assign bus.aborted           = aborted_q;
    assign bus.blocks_retired    = blocks_retired_q;
endmodule

// File: tb/tb_block_dispatcher.sv
// Directed bench for block_dispatcher with 4 cores and 4 threads per block.
// Outputs are sampled 1 time unit after each rising edge, against hand-computed expectations.
// Core completions are driven directly, so the bench sets every backpressure and overlap case.
module tb_block_dispatcher;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    block_dispatcher_if #(.NUM_CORES(4), .COUNT_WIDTH(16), .BLOCK_ID_WIDTH(16), .TC_WIDTH(3)) bus ();

    block_dispatcher #(
        .NUM_CORES(4), .THREADS_PER_BLOCK(4), .COUNT_WIDTH(16), .BLOCK_ID_WIDTH(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [15:0] count);
        bus.launch_valid        = 1'b1;
        bus.launch_thread_count = count;
        tick();
        bus.launch_valid        = 1'b0;
    endtask

    initial begin
        logic [3:0] m;
        checks = 0;
        errors = 0;
        bus.launch_valid        = 1'b0;
        bus.launch_thread_count = '0;
        bus.abort               = 1'b0;
        bus.core_done           = '0;
        reset                   = 1'b1;
        tick();
        tick();
        chk("rst_core_reset", bus.core_reset, 4'hF);
        chk("rst_start", bus.core_start, 4'h0);
        chk("rst_ids", bus.core_block_id, 64'h0);
        chk("rst_tc", bus.core_thread_count, {3'd4, 3'd4, 3'd4, 3'd4});
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_ready", bus.launch_ready, 1'b1);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_aborted", bus.aborted, 1'b0);
        chk("rst_retired", bus.blocks_retired, 16'd0);
        reset = 1'b0;
        tick();
        chk("rel_core_reset", bus.core_reset, 4'h0);

        // count=16: blocks 0..3 to cores 0..3 on consecutive cycles, staggered retirement
        launch(16'd16);
        chk("t1_busy", bus.busy, 1'b1);
        chk("t1_ready", bus.launch_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            m = 4'(1 << i);
            chk("t1_core_reset", bus.core_reset, m);
            m = 4'((1 << i) - 1);
            chk("t1_start", bus.core_start, m);
        end
        tick();
        chk("t1_start_all", bus.core_start, 4'hF);
        chk("t1_ids", bus.core_block_id, {16'd3, 16'd2, 16'd1, 16'd0});
        chk("t1_tc", bus.core_thread_count, {3'd4, 3'd4, 3'd4, 3'd4});
        for (int i = 0; i < 4; i++) begin
            bus.core_done = 4'((2 << i) - 1);
            tick();
            chk("t1_retired", bus.blocks_retired, 16'(i + 1));
            m = ~(4'((2 << i) - 1));
            chk("t1_start_drop", bus.core_start, m);
        end
        bus.core_done = '0;
        chk("t1_done_early", bus.done, 1'b0);
        chk("t1_busy_finish", bus.busy, 1'b1);
        tick();
        chk("t1_done", bus.done, 1'b1);
        chk("t1_busy_fall", bus.busy, 1'b0);
        tick();
        chk("t1_done_pulse", bus.done, 1'b0);

        // count=18: all four retire together, then block 4 (2 threads) goes to core 0
        launch(16'd18);
        for (int i = 0; i < 4; i++) begin
            tick();
            m = 4'(1 << i);
            chk("t3_core_reset", bus.core_reset, m);
        end
        tick();
        chk("t3_start_all", bus.core_start, 4'hF);
        bus.core_done = 4'hF;
        tick();
        bus.core_done = 4'h0;
        chk("t3_retired4", bus.blocks_retired, 16'd4);
        chk("t3_start_none", bus.core_start, 4'h0);
        tick();
        chk("t3_rr_resume", bus.core_reset, 4'b0001);
        chk("t3_ids", bus.core_block_id, {16'd3, 16'd2, 16'd1, 16'd4});
        chk("t3_tc_last", bus.core_thread_count, {3'd4, 3'd4, 3'd4, 3'd2});
        tick();
        chk("t3_start", bus.core_start, 4'b0001);
        bus.core_done = 4'b0001;
        tick();
        bus.core_done = 4'h0;
        chk("t3_retired5", bus.blocks_retired, 16'd5);
        tick();
        chk("t3_done", bus.done, 1'b1);

        // count=26: 7 blocks, rr starts at core 1, late blocks go to the core that frees first
        launch(16'd26);
        tick();
        chk("t2_reset_c2", bus.core_reset, 4'b0010);
        tick();
        chk("t2_reset_c3", bus.core_reset, 4'b0100);
        tick();
        chk("t2_reset_c4", bus.core_reset, 4'b1000);
        tick();
        chk("t2_reset_c5", bus.core_reset, 4'b0001);
        chk("t2_start_c5", bus.core_start, 4'b1110);
        bus.core_done = 4'b0100;
        tick();
        bus.core_done = 4'h0;
        chk("t2_retired1", bus.blocks_retired, 16'd1);
        chk("t2_start_c6", bus.core_start, 4'b1011);
        tick();
        chk("t2_reset_c7", bus.core_reset, 4'b0100);
        chk("t2_ids_c7", bus.core_block_id, {16'd2, 16'd4, 16'd0, 16'd3});
        bus.core_done = 4'b1000;
        tick();
        bus.core_done = 4'h0;
        chk("t2_retired2", bus.blocks_retired, 16'd2);
        chk("t2_start_c8", bus.core_start, 4'b0111);
        tick();
        chk("t2_reset_c9", bus.core_reset, 4'b1000);
        bus.core_done = 4'b0001;
        tick();
        bus.core_done = 4'h0;
        chk("t2_retired3", bus.blocks_retired, 16'd3);
        chk("t2_start_c10", bus.core_start, 4'b1110);
        tick();
        chk("t2_reset_c11", bus.core_reset, 4'b0001);
        chk("t2_ids_c11", bus.core_block_id, {16'd5, 16'd4, 16'd0, 16'd6});
        chk("t2_tc_c11", bus.core_thread_count, {3'd4, 3'd4, 3'd4, 3'd2});
        bus.core_done = 4'hF;
        tick();
        chk("t2_retired6_load_ignored", bus.blocks_retired, 16'd6);
        chk("t2_start_c12", bus.core_start, 4'b0001);
        bus.core_done = 4'b0001;
        tick();
        bus.core_done = 4'h0;
        chk("t2_retired7", bus.blocks_retired, 16'd7);
        chk("t2_done_early", bus.done, 1'b0);
        tick();
        chk("t2_done", bus.done, 1'b1);

        // count=0: straight to FINISH, done two cycles after the handshake, no core activity
        launch(16'd0);
        chk("t4_ready", bus.launch_ready, 1'b0);
        chk("t4_busy", bus.busy, 1'b1);
        chk("t4_done_early", bus.done, 1'b0);
        tick();
        chk("t4_done", bus.done, 1'b1);
        chk("t4_start", bus.core_start, 4'h0);
        chk("t4_ready_back", bus.launch_ready, 1'b1);
        tick();
        chk("t4_done_pulse", bus.done, 1'b0);

        // count=12 to cores 1..3, abort together with a core_done
        launch(16'd12);
        for (int i = 0; i < 4; i++) tick();
        chk("t5_start", bus.core_start, 4'b1110);
        bus.abort     = 1'b1;
        bus.core_done = 4'b0010;
        tick();
        bus.abort     = 1'b0;
        bus.core_done = 4'h0;
        chk("t5_aborted", bus.aborted, 1'b1);
        chk("t5_core_reset", bus.core_reset, 4'hF);
        chk("t5_start", bus.core_start, 4'h0);
        chk("t5_retired", bus.blocks_retired, 16'd0);
        chk("t5_done", bus.done, 1'b0);
        chk("t5_ready_abort", bus.launch_ready, 1'b0);
        bus.launch_valid        = 1'b1;
        bus.launch_thread_count = 16'd4;
        tick();
        chk("t5_aborted_pulse", bus.aborted, 1'b0);
        chk("t5_ready", bus.launch_ready, 1'b1);
        chk("t5_core_reset_clr", bus.core_reset, 4'h0);
        chk("t5_done_after", bus.done, 1'b0);
        tick();
        bus.launch_valid = 1'b0;
        chk("t5_relaunch_busy", bus.busy, 1'b1);
        tick();
        chk("t5_relaunch_grant", bus.core_reset, 4'b0001);

        // reset in the middle of a kernel
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_core_reset", bus.core_reset, 4'hF);
        chk("t6_rst_start", bus.core_start, 4'h0);
        chk("t6_rst_ids", bus.core_block_id, 64'h0);
        chk("t6_rst_busy", bus.busy, 1'b0);
        chk("t6_rst_retired", bus.blocks_retired, 16'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t6_no_done", bus.done, 1'b0);
            chk("t6_no_aborted", bus.aborted, 1'b0);
        end

        // count=8 after reset: core_done on FREE and LOAD slots is ignored
        launch(16'd8);
        tick();
        bus.core_done = 4'b1101;
        tick();
        chk("t7_spurious", bus.blocks_retired, 16'd0);
        bus.core_done = 4'b0011;
        tick();
        chk("t7_retired1", bus.blocks_retired, 16'd1);
        bus.core_done = 4'b0010;
        tick();
        bus.core_done = 4'h0;
        chk("t7_retired2", bus.blocks_retired, 16'd2);
        tick();
        chk("t7_done", bus.done, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
